// File: rtl/vasip_pkg.sv
// Shared vector-ASIP definitions: opcode encoding, instruction field
// positions, the bubble word and the fetch FSM state type.
package vasip_pkg;

    typedef enum logic [3:0] {
        INCRI = 4'h0,
        INCRJ = 4'h1,
        SETN  = 4'h2,
        SUMFV = 4'h3,
        MULFV = 4'h4,
        NOP   = 4'h5,
        LDV   = 4'h6,
        HALT  = 4'hF
    } opcode_t;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;

    localparam logic [31:0] NOP_INSTR = 32'h5000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a synchronous ROM and presents
// one instruction per cycle to decode, honouring stall, drain, HALT and restart.
module fetch_stage #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned PROG_LEN  = 256,
    parameter logic [3:0]  HALT_OP   = 4'hF,
    parameter logic [31:0] NOP_INSTR = 32'h5000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output logic              done,
    output logic [15:0]       instr_cnt
);

    import vasip_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              valid;
    logic              accept;
    logic              halt_hit;
    logic              fetch;
    logic              restart;

    // The ROM holds its output while imem_en is low, so a stalled or halted
    // instruction stays on imem_rdata without a local copy.
    always_comb begin
        accept      = valid & ~stall;
        halt_hit    = accept & (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OP);
        fetch       = (state == RUN) & ~stall & ~halt_hit;
        restart     = start & ((state == IDLE) | (state == DONE));
        imem_en     = fetch;
        imem_addr   = pc;
        instr       = valid ? imem_rdata : NOP_INSTR;
        instr_valid = valid;
        busy        = (state == RUN) | (state == DRAIN);
        done        = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            valid    <= 1'b0;
            instr_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                RUN: begin
                    if (halt_hit) begin
                        state <= DONE;
                        valid <= 1'b0;
                    end else if (fetch) begin
                        valid    <= 1'b1;
                        instr_pc <= pc;
                        if (pc == LAST_PC) begin
                            state <= DRAIN;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state <= DONE;
                        valid <= 1'b0;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W(16)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(restart),
        .inc(accept),
        .q  (instr_cnt)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of small programs plus hand-written stall,
// drain, reset and saturation sequences, with a scoreboard on accepted words.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h5000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [7:0]  instr_pc;
    logic        busy;
    logic        done;
    logic [15:0] instr_cnt;

    fetch_stage #(
        .ADDR_W   (8),
        .PROG_LEN (4),
        .HALT_OP  (4'hF),
        .NOP_INSTR(NOP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .busy       (busy),
        .done       (done),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  rom [256];
    logic [255:0] read_mask;

    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= rom[imem_addr];
            read_mask[imem_addr] = 1'b1;
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    typedef struct {
        logic [3:0][31:0] w;
        int               halt_idx;
    } prog_t;

    sb_t   exp_q[$];
    prog_t progs[5];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic prog_t mk(input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3,
                                 input int h);
        prog_t p;
        p.w[0] = a0;
        p.w[1] = a1;
        p.w[2] = a2;
        p.w[3] = a3;
        p.halt_idx = h;
        return p;
    endfunction

    // Scoreboard: every word decode accepts must match the next expected entry.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (instr_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected: got instr %h pc %h expected nothing", instr, instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_instr", instr, e.instr);
                        chk("sb_pc", {24'h0, instr_pc}, e.pc);
                    end
                end else if (!instr_valid) begin
                    chk("bubble_nop", instr, NOP_W);
                end
            end
        end
    end

    task automatic load_prog(input prog_t p, input int n_exp);
        for (int i = 0; i < 4; i++) rom[i] = p.w[i];
        for (int i = 0; i < n_exp; i++) exp_q.push_back('{instr: p.w[i], pc: i});
        read_mask = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_pc(input logic [7:0] want_pc, input bit use_addr);
        int k = 0;
        while (k < 30 && !(use_addr ? (busy && imem_addr == want_pc)
                                    : (instr_valid && instr_pc == want_pc))) begin
            @(negedge clk);
            k++;
        end
        chk("reach_pc", use_addr ? {24'h0, imem_addr} : {24'h0, instr_pc}, {24'h0, want_pc});
    endtask

    initial begin
        int n;
        int cnt;

        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        read_mask = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;

        progs[0] = mk(32'h1000_00A0, 32'h2000_00A1, 32'h3000_00A2, 32'h6000_00A3, -1);
        progs[1] = mk(32'h0000_0B00, 32'h4000_0B01, 32'hF000_0000, 32'h3000_0B03, 2);
        progs[2] = mk(32'h7123_4567, 32'h9ABC_DEF0, 32'hE000_0001, 32'hC0FF_EE00, -1);
        progs[3] = mk(32'hF123_4567, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0);
        progs[4] = mk(32'h5000_0000, 32'h8765_4321, 32'h2000_0042, 32'hFABC_0000, 3);

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, NOP_W);
        chk("rst_pc", {24'h0, instr_pc}, 32'h0);
        chk("rst_cnt", {16'h0, instr_cnt}, 32'h0);
        chk("rst_flags", {28'h0, busy, done, imem_en, 1'b0}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven programs
        for (int t = 0; t < 5; t++) begin
            cnt = (progs[t].halt_idx < 0) ? 4 : progs[t].halt_idx + 1;
            load_prog(progs[t], cnt);
            pulse_start();
            wait_done(n);
            #1;
            chk("latency", n, cnt + 1);
            chk("end_cnt", {16'h0, instr_cnt}, cnt);
            chk("end_valid", {31'h0, instr_valid}, 32'h0);
            chk("end_instr", instr, NOP_W);
            chk("end_busy", {31'h0, busy}, 32'h0);
            chk("rom_reads", read_mask[31:0], (32'h1 << cnt) - 1);
            chk("sb_drained", exp_q.size(), 32'h0);
        end

        // Stall while A1 is presented
        load_prog(progs[0], 4);
        pulse_start();
        wait_pc(8'd1, 1'b0);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_instr", instr, progs[0].w[1]);
            chk("stall_pc", {24'h0, instr_pc}, 32'h1);
            chk("stall_en", {31'h0, imem_en}, 32'h0);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("unstall_instr", instr, progs[0].w[1]);
        chk("unstall_en", {31'h0, imem_en}, 32'h1);
        wait_done(n);
        #1;
        chk("stall_cnt", {16'h0, instr_cnt}, 32'd4);
        chk("stall_sb", exp_q.size(), 32'h0);

        // Stall held in DRAIN
        load_prog(progs[0], 4);
        pulse_start();
        wait_pc(8'd3, 1'b0);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("drain_busy", {31'h0, busy}, 32'h1);
            chk("drain_done", {31'h0, done}, 32'h0);
            chk("drain_valid", {31'h0, instr_valid}, 32'h1);
            chk("drain_instr", instr, progs[0].w[3]);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("drain_last", {31'h0, done}, 32'h0);
        @(negedge clk);
        #1;
        chk("drain_to_done", {31'h0, done}, 32'h1);
        chk("drain_cnt", {16'h0, instr_cnt}, 32'd4);

        // Asynchronous reset mid-RUN, then restart with an ignored start pulse
        load_prog(progs[0], 4);
        pulse_start();
        wait_pc(8'd2, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_instr", instr, NOP_W);
        chk("arst_flags", {29'h0, busy, done, imem_en}, 32'h0);
        chk("arst_addr", {24'h0, imem_addr}, 32'h0);
        chk("arst_cnt", {16'h0, instr_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        load_prog(progs[0], 4);
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ign_start_busy", {31'h0, busy}, 32'h1);
        wait_done(n);
        #1;
        chk("ign_start_cnt", {16'h0, instr_cnt}, 32'd4);
        chk("ign_start_sb", exp_q.size(), 32'h0);

        // Saturation; start under stall must still enter RUN
        load_prog(progs[0], 4);
        @(negedge clk);
        stall = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("stall_start_busy", {31'h0, busy}, 32'h1);
        chk("stall_start_en", {31'h0, imem_en}, 32'h0);
        force dut.u_cnt.q = 16'hFFFE;
        @(negedge clk);
        release dut.u_cnt.q;
        #1;
        chk("preset_cnt", {16'h0, instr_cnt}, 32'h0000_FFFE);
        @(negedge clk);
        stall = 1'b0;
        wait_done(n);
        #1;
        chk("sat_cnt", {16'h0, instr_cnt}, 32'h0000_FFFF);
        chk("sat_sb", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
